// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: data width, reset
// address and the fetch FSM state type.
package fetch_stage_pkg;
  localparam int XLEN = 32;
  localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'hBFC0_0000;

  typedef enum logic {
    FETCH = 1'b0,
    DROP  = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/fetch_skid_buf.sv
// Decode-stage output register plus a one-entry skid that absorbs the
// response which arrives while downstream is stalled.
module fetch_skid_buf
  import fetch_stage_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            stall,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic            valid_D,
  output logic            skid_full
);

  logic [XLEN-1:0] skid_instr;
  logic [XLEN-1:0] skid_pc;

  // Output register and skid entry update; flush drops everything in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_D    <= 1'b0;
      Instr      <= 32'h0000_0000;
      PC_D       <= 32'h0000_0000;
      PCPlus4_D  <= 32'h0000_0000;
      skid_full  <= 1'b0;
      skid_instr <= 32'h0000_0000;
      skid_pc    <= 32'h0000_0000;
    end else if (flush) begin
      valid_D   <= 1'b0;
      skid_full <= 1'b0;
    end else if (!valid_D || !stall) begin
      if (skid_full) begin
        Instr     <= skid_instr;
        PC_D      <= skid_pc;
        PCPlus4_D <= skid_pc + 32'd4;
        valid_D   <= 1'b1;
        skid_full <= 1'b0;
      end else if (in_valid) begin
        Instr     <= in_instr;
        PC_D      <= in_pc;
        PCPlus4_D <= in_pc + 32'd4;
        valid_D   <= 1'b1;
      end else begin
        valid_D <= 1'b0;
      end
    end else if (in_valid) begin
      // Requests stop while the skid is full, so it can never overflow here
      skid_instr <= in_instr;
      skid_pc    <= in_pc;
      skid_full  <= 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC register, request handshake and redirect handling,
// with a DROP state that discards the response of an abandoned request.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_ready,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic [XLEN-1:0] Instr,
  output logic [XLEN-1:0] PC_D,
  output logic [XLEN-1:0] PCPlus4_D,
  output logic            valid_D
);

  fetch_state_e    state, state_next;
  logic [XLEN-1:0] pc, pc_next;
  logic [XLEN-1:0] saved, saved_next;
  logic            skid_full;
  logic            complete;
  logic            accept;
  logic [XLEN-1:0] target;

  assign imem_req  = rst_n & ~skid_full;
  assign imem_addr = pc;
  assign complete  = imem_req & imem_ready;
  assign target    = redirect_pc & ~32'h0000_0003;
  assign accept    = (state == FETCH) & complete & ~redirect;

  // Next PC, saved redirect target and FSM state
  always_comb begin
    state_next = state;
    pc_next    = pc;
    saved_next = saved;
    case (state)
      FETCH: begin
        if (redirect) begin
          if (imem_req && !imem_ready) begin
            saved_next = target;
            state_next = DROP;
          end else begin
            pc_next = target;
          end
        end else if (complete) begin
          pc_next = pc + 32'd4;
        end else begin
          pc_next = pc;
        end
      end
      DROP: begin
        if (complete) begin
          pc_next    = redirect ? target : saved;
          state_next = FETCH;
        end else if (redirect) begin
          saved_next = target;
        end else begin
          saved_next = saved;
        end
      end
      default: begin
        state_next = FETCH;
      end
    endcase
  end

  // PC, target and FSM state registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= FETCH;
      pc    <= RESET_PC;
      saved <= RESET_PC;
    end else begin
      state <= state_next;
      pc    <= pc_next;
      saved <= saved_next;
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect),
    .stall     (stall),
    .in_valid  (accept),
    .in_instr  (imem_rdata),
    .in_pc     (pc),
    .Instr     (Instr),
    .PC_D      (PC_D),
    .PCPlus4_D (PCPlus4_D),
    .valid_D   (valid_D),
    .skid_full (skid_full)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage; the memory returns address + 0x10000000 so
// every expected instruction word below is a hand-computed constant.
module tb_fetch_stage;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] Instr;
  logic [31:0] PC_D;
  logic [31:0] PCPlus4_D;
  logic        valid_D;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  assign imem_rdata = imem_addr + 32'h1000_0000;

  fetch_stage dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rdata  (imem_rdata),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .Instr       (Instr),
    .PC_D        (PC_D),
    .PCPlus4_D   (PCPlus4_D),
    .valid_D     (valid_D)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0000_0000;
    step(); step();
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    // Reset state and streaming with zero-wait memory
    rst_n = 1'b0; imem_ready = 1'b1; stall = 1'b0;
    redirect = 1'b0; redirect_pc = 32'h0000_0000;
    step(); step();
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, valid_D}, 32'd0);
    check("rst_instr", Instr, 32'h0000_0000);
    check("rst_pcd", PC_D, 32'h0000_0000);
    check("rst_pc4", PCPlus4_D, 32'h0000_0000);
    rst_n = 1'b1; #1;
    check("s_addr0", imem_addr, 32'hBFC0_0000);
    check("s_req0", {31'd0, imem_req}, 32'd1);
    step();
    check("s_addr1", imem_addr, 32'hBFC0_0004);
    check("s_valid1", {31'd0, valid_D}, 32'd1);
    check("s_pcd1", PC_D, 32'hBFC0_0000);
    check("s_pc4_1", PCPlus4_D, 32'hBFC0_0004);
    check("s_instr1", Instr, 32'hCFC0_0000);
    step();
    check("s_addr2", imem_addr, 32'hBFC0_0008);
    check("s_pcd2", PC_D, 32'hBFC0_0004);
    step();
    check("s_pcd3", PC_D, 32'hBFC0_0008);

    // Wait states at BFC00004
    do_reset();
    step();
    imem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("w_req", {31'd0, imem_req}, 32'd1);
      check("w_addr", imem_addr, 32'hBFC0_0004);
      check("w_valid", {31'd0, valid_D}, 32'd0);
    end
    imem_ready = 1'b1;
    step();
    check("w_valid_end", {31'd0, valid_D}, 32'd1);
    check("w_instr", Instr, 32'hCFC0_0004);
    check("w_addr_next", imem_addr, 32'hBFC0_0008);

    // Stall for four cycles: one response parks in the skid
    do_reset();
    step();
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("st_pcd", PC_D, 32'hBFC0_0000);
      check("st_instr", Instr, 32'hCFC0_0000);
      check("st_valid", {31'd0, valid_D}, 32'd1);
      check("st_req", {31'd0, imem_req}, 32'd0);
    end
    stall = 1'b0;
    step();
    check("st_rel_pcd", PC_D, 32'hBFC0_0004);
    check("st_rel_instr", Instr, 32'hCFC0_0004);
    check("st_rel_req", {31'd0, imem_req}, 32'd1);
    check("st_rel_addr", imem_addr, 32'hBFC0_0008);
    step();
    check("st_pcd_08", PC_D, 32'hBFC0_0008);
    step();
    check("st_pcd_0c", PC_D, 32'hBFC0_000C);

    // Redirect while a request is outstanding
    do_reset();
    step();
    imem_ready = 1'b0;
    step();
    redirect = 1'b1; redirect_pc = 32'h8000_0102;
    step();
    redirect = 1'b0;
    check("rd_valid0", {31'd0, valid_D}, 32'd0);
    check("rd_hold_addr", imem_addr, 32'hBFC0_0004);
    check("rd_hold_req", {31'd0, imem_req}, 32'd1);
    imem_ready = 1'b1;
    step();
    check("rd_valid1", {31'd0, valid_D}, 32'd0);
    check("rd_addr", imem_addr, 32'h8000_0100);
    step();
    check("rd_valid2", {31'd0, valid_D}, 32'd1);
    check("rd_pcd", PC_D, 32'h8000_0100);
    check("rd_instr", Instr, 32'h9000_0100);

    // Second redirect during DROP overwrites the saved target
    do_reset();
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    redirect_pc = 32'h8000_0200;
    step();
    redirect = 1'b0; imem_ready = 1'b1;
    step();
    check("ov_addr", imem_addr, 32'h8000_0200);
    check("ov_valid", {31'd0, valid_D}, 32'd0);

    // Redirect coinciding with the DROP completion takes the newest target
    do_reset();
    imem_ready = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h8000_0100;
    step();
    imem_ready = 1'b1; redirect_pc = 32'h8000_0300;
    step();
    redirect = 1'b0;
    check("nw_addr", imem_addr, 32'h8000_0300);
    step();
    check("nw_pcd", PC_D, 32'h8000_0300);

    // Redirect together with stall while the skid is full
    do_reset();
    step();
    stall = 1'b1;
    step();
    check("rs_req_full", {31'd0, imem_req}, 32'd0);
    redirect = 1'b1; redirect_pc = 32'h0000_1000;
    step();
    redirect = 1'b0;
    check("rs_valid", {31'd0, valid_D}, 32'd0);
    check("rs_req", {31'd0, imem_req}, 32'd1);
    check("rs_addr", imem_addr, 32'h0000_1000);
    stall = 1'b0;
    step();
    check("rs_pcd", PC_D, 32'h0000_1000);
    check("rs_instr", Instr, 32'h1000_1000);

    // PC wrap-around from FFFFFFFC to 0
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    step();
    redirect = 1'b0;
    check("wr_valid", {31'd0, valid_D}, 32'd0);
    check("wr_addr0", imem_addr, 32'hFFFF_FFFC);
    step();
    check("wr_pcd", PC_D, 32'hFFFF_FFFC);
    check("wr_pc4", PCPlus4_D, 32'h0000_0000);
    check("wr_instr", Instr, 32'h0FFF_FFFC);
    check("wr_addr1", imem_addr, 32'h0000_0000);

    // Reset during a wait abandons the request
    do_reset();
    step();
    imem_ready = 1'b0;
    step();
    rst_n = 1'b0; #1;
    check("mr_req_low", {31'd0, imem_req}, 32'd0);
    step();
    check("mr_req_rst", {31'd0, imem_req}, 32'd0);
    check("mr_valid", {31'd0, valid_D}, 32'd0);
    rst_n = 1'b1; imem_ready = 1'b1; #1;
    check("mr_req", {31'd0, imem_req}, 32'd1);
    check("mr_addr", imem_addr, 32'hBFC0_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/fetch_stage.md
FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'hBFC00000, meaning the first instruction address after reset.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1, the reset; synchronous, active-low.
REQ-004 The block SHALL have port imem_req, output, 1, the instruction-memory read request.
REQ-005 The block SHALL have port imem_addr, output, 32, the word-aligned read address.
REQ-006 The block SHALL have port imem_ready, input, 1; imem_rdata is valid and the request completes in a cycle where imem_req and imem_ready are both 1.
REQ-007 The block SHALL have port imem_rdata, input, 32, the read instruction word.
REQ-008 The block SHALL have port stall, input, 1; 1 means downstream does not consume Instr this cycle.
REQ-009 The block SHALL have ports redirect (input, 1) and redirect_pc (input, 32): a taken branch/jump target from execute.
REQ-010 The block SHALL have ports Instr (output, 32), PC_D (output, 32), PCPlus4_D (output, 32) and valid_D (output, 1): the decode-stage instruction word feeding the immediate extender and control unit, with its address.

Function
REQ-011 The block SHALL keep a PC register and a two-state FSM: FETCH (normal) and DROP (discard one outstanding stale response).
REQ-012 In FETCH, imem_req SHALL be 1 when the skid entry is empty, and imem_addr SHALL equal PC.
REQ-013 Once imem_req is 1 without imem_ready, imem_req and imem_addr SHALL hold stable until the completing cycle; reset is the only exception.
REQ-014 On a completing cycle in FETCH without redirect, PC SHALL advance by 4, with 32-bit wrap-around from 32'hFFFFFFFC to 0.
REQ-015 The response SHALL load the output register (Instr, PC_D, PCPlus4_D=PC_D+4, valid_D=1) when valid_D is 0 or stall is 0; otherwise it loads the single skid entry.
REQ-016 Latency SHALL be one cycle from the completing cycle to valid_D; zero-wait memory without stall SHALL give one instruction per cycle.
REQ-017 While valid_D and stall are both 1, Instr, PC_D, PCPlus4_D and valid_D SHALL hold unchanged.
REQ-018 When stall falls with the skid full, the skid entry SHALL move to the output register next cycle, and requests SHALL resume the same cycle the skid empties.
REQ-019 When valid_D=1, stall=0, skid empty and no response arrives, valid_D SHALL go to 0 next cycle.
REQ-020 On redirect=1 (priority over stall), next cycle valid_D SHALL be 0 and the skid SHALL be empty; redirect_pc[1:0] SHALL be ignored and treated as 00.
REQ-021 On redirect with no outstanding request, or on a completing cycle, any same-cycle response SHALL be discarded, PC<=redirect_pc, and the FSM SHALL stay in FETCH.
REQ-022 On redirect while a request is outstanding (imem_req=1, imem_ready=0), the target SHALL be saved, the FSM SHALL enter DROP and the request SHALL hold.
REQ-023 In DROP, the completing response SHALL be discarded, PC SHALL load the saved target, and the FSM SHALL return to FETCH.
REQ-024 A second redirect in DROP SHALL overwrite the saved target.
REQ-025 A redirect on the same cycle as the DROP completion SHALL take the newest target.

Reset
REQ-026 While rst_n=0 at a clock edge, next state SHALL be: PC=RESET_PC, FSM=FETCH, valid_D=0, skid empty, Instr=0, PC_D=0, PCPlus4_D=0.
REQ-027 imem_req SHALL be 0 while rst_n=0, abandoning any outstanding request.
REQ-028 The first request, addr=RESET_PC, SHALL be issued the cycle after rst_n rises.

Structure
REQ-029 A shared package SHALL hold the RESET_PC default, the fetch FSM state typedef, and the XLEN=32 constant.
REQ-030 The one-entry skid plus output register SHALL be the sub-module fetch_skid_buf; PC/FSM logic stays in fetch_stage.

Verification
REQ-031 Reset then zero-wait memory, stall=0: imem_addr=BFC00000, BFC00004, BFC00008 on consecutive cycles, with valid_D=1 and PC_D following one cycle later.
REQ-032 imem_ready held low 3 cycles at addr BFC00004: imem_req/imem_addr stay stable, valid_D=0 in the gap, then Instr = response word.
REQ-033 stall=1 for 4 cycles with zero-wait memory: outputs stay frozen, one response goes to the skid, imem_req drops, and on release instructions emerge in order with no loss or duplicate.
REQ-034 redirect to 0x80000102 while a request is outstanding: the stale response is discarded, the next imem_addr=0x80000100, and valid_D=0 until that response arrives.
REQ-035 redirect the same cycle as stall=1 with the skid full: valid_D=0 next cycle, the skid is cleared, and fetch restarts at the target.
REQ-036 rst_n low mid-wait, then high: imem_req=0 during reset and the next request goes to BFC00000.
